fft_frame_packer: RTL and testbench
===================================

Name: fft_frame_packer

Overview:
- Transmitter side of the 16-lane FFT result interface.
- Collects one complex FFT output word per cycle from the serial FFT datapath into a 16-entry frame buffer and undoes bit-reversed ordering.
- Presents all 16 bins in parallel on fft_d0..fft_d15 with a single-cycle fft_valid strobe, which is what the spectrum analysis stage consumes.
- Double-buffered, so input can stream back-to-back frames with no bubbles.

Parameters:
- BIT_REV, 1, 1 = input word k is bin bitrev4(k); 0 = input word k is bin k.
- DW, 32, word width; fixed split: real [31:16], imag [15:0], both signed Q-format and passed through untouched.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input word present this cycle.
- in_data  in  32  {real[15:0], imag[15:0]} of the current FFT output.
- in_ready  out  1  packer can accept a word this cycle (constant 1 unless FFT_PACK_HOLD_EN).
- in_clear  in  1  synchronous frame flush; discards the partial frame.
- fft_d0 .. fft_d15  out  32 each  bin 0..15 of the last completed frame.
- fft_valid  out  1  one-cycle pulse: fft_d* hold a new frame.
- frame_err  out  1  sticky; set when in_clear aborts a partial frame (wr_cnt != 0).

Behaviour:
- Reset (async): wr_cnt=0; buffer and all fft_d* = 0; fft_valid=0; frame_err=0; in_ready=1.
- Accept condition: in_valid && in_ready.
- On accept, buf[lane] <= in_data, where lane = BIT_REV ? {k[0],k[1],k[2],k[3]} : k and k = wr_cnt. Then wr_cnt increments, wrapping 15 -> 0.
- Frame completion: on an accept with wr_cnt==15, at that same edge, all fft_d* load from buf, with the lane of the current word taken directly from in_data (bypass). fft_valid=1 in the following cycle only. Latency is 1 cycle from the 16th accepted word to fft_valid.
- fft_d* hold their value until the next completion. The downstream block registers them on fft_valid, so they are stable for at least 1 cycle.
- Back-to-back frames: the first word of the next frame may be accepted in the cycle fft_valid is high. The minimum fft_valid spacing is 16 cycles.
- Gaps: in_valid low stalls wr_cnt. There is no timeout.
- in_clear: wr_cnt <= 0 and no fft_valid. If wr_cnt != 0, frame_err <= 1. in_clear has priority over a simultaneous accept; that word is dropped. fft_d* are unaffected.
- frame_err clears only on rst.
- Mid-frame rst: partial frame lost; outputs return to reset values asynchronously.
- No arithmetic: data are bit-exact copies. Sign is preserved because no widening is done.

Optional Feature:
- Macro FFT_PACK_HOLD_EN.
- Defined: adds a pending flag, set when fft_valid is issued and cleared by new input done_in (1 bit, from the analysis stage's done).
  - While pending && wr_cnt==15, in_ready=0, so the 16th word waits.
  - If done_in arrives in the same cycle as the set, set wins only if it is a new completion; done_in clears the older pending.
  - At most one frame is in flight downstream.
- Not defined: done_in port is absent, in_ready is tied to 1, and frames issue freely. This is the default, since the downstream pipeline is fully pipelined.

Decomposition:
- Shared package (fft_pkg):
  - FFT_N=16, FFT_LOG2N=4.
  - Word field constants RE_MSB=31, RE_LSB=16, IM_MSB=15, IM_LSB=0.
  - Function bitrev4.
  - Typedef cplx_word_t (packed struct re/im, 16 bits each).
- One sub-module is natural: fft_bitrev_addr (4-bit combinational index remap, selectable by BIT_REV), reusable by the FFT input loader.
- Everything else stays flat in fft_frame_packer.

Test Plan:
- Reset then BIT_REV=1, feed in_data = {k, 16'hFF00+k} for k=0..15 on consecutive cycles -> fft_valid for 1 cycle, 1 cycle after k=15; fft_d8 = {16'd1, 16'hFF01}, fft_d12 = {16'd3, 16'hFF03}, fft_d15 = {16'd15, 16'hFF0F}.
- BIT_REV=0, 32 consecutive words with values 0..31 -> two fft_valid pulses exactly 16 cycles apart; second frame fft_dN = N+16; first frame held in between.
- Inject in_valid gaps (every 3rd cycle low) across a frame -> same fft_d* as the gap-free case; fft_valid only after the 16th accept.
- in_clear after 5 words, then a full 16-word frame -> frame_err=1; exactly one fft_valid carrying only the post-clear words. in_clear asserted together with the 16th word -> no fft_valid.
- Assert rst at word 9 of a frame -> all fft_d*=0, fft_valid=0, frame_err=0 immediately; the next full frame packs correctly from word 0.
- FFT_PACK_HOLD_EN: complete frame 1, withhold done_in -> in_ready drops when wr_cnt==15 of frame 2; pulse done_in -> in_ready=1 the next cycle; frame 2 fft_valid follows its 16th accept by 1 cycle.

Source files
------------

// File: rtl/fft_pkg.sv
// fft_pkg: shared constants, word layout and index helpers for the FFT result path.
//   FFT_N / FFT_LOG2N : frame size and index width.
//   RE_* / IM_*       : bit positions of the real and imaginary fields in a 32-bit word.
//   cplx_word_t       : packed {re, im} view of a word.
//   bitrev4           : 4-bit index bit reversal.
package fft_pkg;
   localparam int FFT_N     = 16;
   localparam int FFT_LOG2N = 4;
   localparam int RE_MSB    = 31;
   localparam int RE_LSB    = 16;
   localparam int IM_MSB    = 15;
   localparam int IM_LSB    = 0;

   typedef struct packed {
      logic signed [15:0] re;
      logic signed [15:0] im;
   } cplx_word_t;

   function automatic logic [FFT_LOG2N-1:0] bitrev4(input logic [FFT_LOG2N-1:0] k);
      return {k[0], k[1], k[2], k[3]};
   endfunction
endpackage

// File: rtl/fft_bitrev_addr.sv
// fft_bitrev_addr: combinational index remap, bit-reversed when BIT_REV != 0.
//   idx  in  4  sequential word index
//   addr out 4  bin index the word belongs to
module fft_bitrev_addr
   import fft_pkg::*;
#(
   parameter int BIT_REV = 1
) (
   input  logic [FFT_LOG2N-1:0] idx,
   output logic [FFT_LOG2N-1:0] addr
);
   assign addr = (BIT_REV != 0) ? bitrev4(idx) : idx;
endmodule

// File: rtl/fft_frame_packer.sv
// fft_frame_packer: gathers 16 serial FFT words, undoes bit reversal, presents the frame in parallel.
//   clk, rst (async, active high)
//   in_valid/in_data/in_ready : serial word input, accepted when in_valid && in_ready
//   in_clear                  : flush the partial frame (sets frame_err if words were pending)
//   fft_d0..fft_d15           : bins of the last completed frame, held until the next one
//   fft_valid                 : one-cycle strobe one cycle after the 16th accepted word
//   frame_err                 : sticky partial-frame-abort flag
//   done_in (FFT_PACK_HOLD_EN only) : downstream finished the previous frame
// Optional macro FFT_PACK_HOLD_EN: allow only one frame in flight downstream.
module fft_frame_packer
   import fft_pkg::*;
#(
   parameter int BIT_REV = 1,
   parameter int DW      = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          in_ready,
   input  logic          in_clear,
`ifdef FFT_PACK_HOLD_EN
   input  logic          done_in,
`endif
   output logic [DW-1:0] fft_d0,
   output logic [DW-1:0] fft_d1,
   output logic [DW-1:0] fft_d2,
   output logic [DW-1:0] fft_d3,
   output logic [DW-1:0] fft_d4,
   output logic [DW-1:0] fft_d5,
   output logic [DW-1:0] fft_d6,
   output logic [DW-1:0] fft_d7,
   output logic [DW-1:0] fft_d8,
   output logic [DW-1:0] fft_d9,
   output logic [DW-1:0] fft_d10,
   output logic [DW-1:0] fft_d11,
   output logic [DW-1:0] fft_d12,
   output logic [DW-1:0] fft_d13,
   output logic [DW-1:0] fft_d14,
   output logic [DW-1:0] fft_d15,
   output logic          fft_valid,
   output logic          frame_err
);
   logic [FFT_LOG2N-1:0] wr_cnt, lane;
   logic [DW-1:0]        buf_q  [FFT_N];
   logic [DW-1:0]        dout_q [FFT_N];
   logic                 accept, last, wr_en, done;

   fft_bitrev_addr #(.BIT_REV(BIT_REV)) u_addr (.idx(wr_cnt), .addr(lane));

   assign accept = in_valid && in_ready;
   assign last   = wr_cnt == FFT_LOG2N'(FFT_N - 1);
   assign wr_en  = accept && !in_clear;
   assign done   = wr_en && last;

`ifdef FFT_PACK_HOLD_EN
   logic pending;
   // A new completion outranks a simultaneous done_in, which belongs to the older frame.
   always_ff @(posedge clk or posedge rst)
      if (rst) pending <= 1'b0;
      else pending <= done ? 1'b1 : (done_in ? 1'b0 : pending);
   assign in_ready = !(pending && last);
`else
   assign in_ready = 1'b1;
`endif

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wr_cnt    <= '0;
         fft_valid <= 1'b0;
         frame_err <= 1'b0;
         for (int i = 0; i < FFT_N; i++) begin
            buf_q[i]  <= '0;
            dout_q[i] <= '0;
         end
      end else begin
         wr_cnt    <= in_clear ? '0 : (accept ? wr_cnt + 1'b1 : wr_cnt);
         fft_valid <= done;
         frame_err <= frame_err | (in_clear && wr_cnt != '0);
         // The 16th word is bypassed straight into its output lane.
         for (int i = 0; i < FFT_N; i++) begin
            if (wr_en && lane == FFT_LOG2N'(i)) buf_q[i] <= in_data;
            if (done) dout_q[i] <= (lane == FFT_LOG2N'(i)) ? in_data : buf_q[i];
         end
      end

   assign fft_d0  = dout_q[0];
   assign fft_d1  = dout_q[1];
   assign fft_d2  = dout_q[2];
   assign fft_d3  = dout_q[3];
   assign fft_d4  = dout_q[4];
   assign fft_d5  = dout_q[5];
   assign fft_d6  = dout_q[6];
   assign fft_d7  = dout_q[7];
   assign fft_d8  = dout_q[8];
   assign fft_d9  = dout_q[9];
   assign fft_d10 = dout_q[10];
   assign fft_d11 = dout_q[11];
   assign fft_d12 = dout_q[12];
   assign fft_d13 = dout_q[13];
   assign fft_d14 = dout_q[14];
   assign fft_d15 = dout_q[15];
endmodule

// File: tb/tb_fft_frame_packer.sv
// tb_fft_frame_packer: drives a BIT_REV=1 and a BIT_REV=0 packer in lockstep against a frame-level model.
module tb_fft_frame_packer;
   logic clk = 0, rst = 1, in_valid = 0, in_clear = 0, done_in = 0;
   logic [31:0] in_data = 0;
   logic rdy1, rdy0, v1, v0, err1, err0;
   logic [15:0][31:0] o1, o0;

   always #5 clk = ~clk;

   fft_frame_packer #(.BIT_REV(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy1), .in_clear(in_clear),
`ifdef FFT_PACK_HOLD_EN
      .done_in(done_in),
`endif
      .fft_d0(o1[0]), .fft_d1(o1[1]), .fft_d2(o1[2]), .fft_d3(o1[3]),
      .fft_d4(o1[4]), .fft_d5(o1[5]), .fft_d6(o1[6]), .fft_d7(o1[7]),
      .fft_d8(o1[8]), .fft_d9(o1[9]), .fft_d10(o1[10]), .fft_d11(o1[11]),
      .fft_d12(o1[12]), .fft_d13(o1[13]), .fft_d14(o1[14]), .fft_d15(o1[15]),
      .fft_valid(v1), .frame_err(err1));

   fft_frame_packer #(.BIT_REV(0)) dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy0), .in_clear(in_clear),
`ifdef FFT_PACK_HOLD_EN
      .done_in(done_in),
`endif
      .fft_d0(o0[0]), .fft_d1(o0[1]), .fft_d2(o0[2]), .fft_d3(o0[3]),
      .fft_d4(o0[4]), .fft_d5(o0[5]), .fft_d6(o0[6]), .fft_d7(o0[7]),
      .fft_d8(o0[8]), .fft_d9(o0[9]), .fft_d10(o0[10]), .fft_d11(o0[11]),
      .fft_d12(o0[12]), .fft_d13(o0[13]), .fft_d14(o0[14]), .fft_d15(o0[15]),
      .fft_valid(v0), .frame_err(err0));

   int n_chk = 0, n_pass = 0;
   logic [31:0] wq[$];
   logic [15:0][31:0] e1 = '0, e0 = '0;
   bit m_valid = 0, m_err = 0, m_pend = 0, m_rdy = 1, auto_done = 1;

   function automatic int rv(input int k);
      int r = 0;
      for (int b = 0; b < 4; b++) if (((k >> b) & 1) != 0) r |= 1 << (3 - b);
      return r;
   endfunction

   // One clock: drive inputs, advance the frame model, sample 1 time unit after the edge.
   task automatic cyc(input bit v, input logic [31:0] d, input bit c, input bit dn = 0);
      bit comp = 0;
      in_valid = v; in_data = d; in_clear = c; done_in = dn | auto_done;
      if (c) begin
         if (wq.size() != 0) m_err = 1;
         wq.delete();
      end else if (v && m_rdy) begin
         wq.push_back(d);
         if (wq.size() == 16) begin
            for (int k = 0; k < 16; k++) begin
               e0[k] = wq[k];
               e1[rv(k)] = wq[k];
            end
            wq.delete();
            comp = 1;
         end
      end
`ifdef FFT_PACK_HOLD_EN
      if (comp) m_pend = 1;
      else if (done_in) m_pend = 0;
      m_rdy = !(m_pend && wq.size() == 15);
`endif
      m_valid = comp;
      @(posedge clk); #1;
      in_valid = 0; in_clear = 0; done_in = 0;
   endtask

   task automatic model_reset;
      wq.delete(); e1 = '0; e0 = '0;
      m_valid = 0; m_err = 0; m_pend = 0; m_rdy = 1;
   endtask

   task automatic test_reset;
      rst = 1;
      repeat (2) @(posedge clk);
      #1;
      n_chk++; if (v1 !== 0 || v0 !== 0) $display("FAIL reset_valid: got %b/%b exp 0", v1, v0); else n_pass++;
      n_chk++; if (err1 !== 0 || err0 !== 0) $display("FAIL reset_err: got %b/%b exp 0", err1, err0); else n_pass++;
      n_chk++; if (rdy1 !== 1 || rdy0 !== 1) $display("FAIL reset_ready: got %b/%b exp 1", rdy1, rdy0); else n_pass++;
      n_chk++; if (o1 !== '0 || o0 !== '0) $display("FAIL reset_data: got %h / %h exp 0", o1, o0); else n_pass++;
      rst = 0;
      model_reset();
   endtask

   task automatic test_bitrev;
      for (int k = 0; k < 16; k++) begin
         cyc(1, {16'(k), 16'hFF00 + 16'(k)}, 0);
         n_chk++; if (v1 !== m_valid || v0 !== m_valid) $display("FAIL bitrev_valid k=%0d: got %b/%b exp %b", k, v1, v0, m_valid); else n_pass++;
      end
      n_chk++; if (o1[8] !== {16'd1, 16'hFF01}) $display("FAIL bitrev_d8: got %h exp %h", o1[8], {16'd1, 16'hFF01}); else n_pass++;
      n_chk++; if (o1[12] !== {16'd3, 16'hFF03}) $display("FAIL bitrev_d12: got %h exp %h", o1[12], {16'd3, 16'hFF03}); else n_pass++;
      n_chk++; if (o1[15] !== {16'd15, 16'hFF0F}) $display("FAIL bitrev_d15: got %h exp %h", o1[15], {16'd15, 16'hFF0F}); else n_pass++;
      for (int i = 0; i < 16; i++) begin
         n_chk++; if (o1[i] !== e1[i] || o0[i] !== e0[i]) $display("FAIL bitrev_lane %0d: got %h/%h exp %h/%h", i, o1[i], o0[i], e1[i], e0[i]); else n_pass++;
      end
      cyc(0, 0, 0);
      n_chk++; if (v1 !== 0 || v0 !== 0) $display("FAIL bitrev_pulse_width: got %b/%b exp 0", v1, v0); else n_pass++;
      n_chk++; if (o1 !== e1 || o0 !== e0) $display("FAIL bitrev_hold: got %h exp %h", o0, e0); else n_pass++;
   endtask

   task automatic test_back_to_back;
      int pulses[$];
      for (int k = 0; k < 32; k++) begin
         cyc(1, 32'(k), 0);
         n_chk++; if (v1 !== m_valid || v0 !== m_valid) $display("FAIL b2b_valid k=%0d: got %b/%b exp %b", k, v1, v0, m_valid); else n_pass++;
         if (v0) pulses.push_back(k);
         if (k == 24) for (int i = 0; i < 16; i++) begin
            n_chk++; if (o0[i] !== 32'(i)) $display("FAIL b2b_hold lane %0d: got %h exp %h", i, o0[i], i); else n_pass++;
         end
      end
      n_chk++; if (pulses.size() != 2) $display("FAIL b2b_pulse_count: got %0d exp 2", pulses.size()); else n_pass++;
      if (pulses.size() == 2) begin
         n_chk++; if (pulses[1] - pulses[0] != 16) $display("FAIL b2b_spacing: got %0d exp 16", pulses[1] - pulses[0]); else n_pass++;
      end
      for (int i = 0; i < 16; i++) begin
         n_chk++; if (o0[i] !== 32'(i + 16) || o1[i] !== e1[i]) $display("FAIL b2b_frame2 lane %0d: got %h/%h exp %h/%h", i, o0[i], o1[i], i + 16, e1[i]); else n_pass++;
      end
   endtask

   task automatic test_gaps;
      int acc = 0, t = 0;
      while (acc < 16 && t < 100) begin
         bit v = (t % 3) != 2;
         cyc(v, $urandom, 0);
         if (v) acc++;
         t++;
         n_chk++; if (v1 !== m_valid || v0 !== m_valid) $display("FAIL gaps_valid t=%0d: got %b/%b exp %b", t, v1, v0, m_valid); else n_pass++;
      end
      n_chk++; if (acc != 16) $display("FAIL gaps_timeout: got %0d exp 16", acc); else n_pass++;
      n_chk++; if (v1 !== 1 || v0 !== 1) $display("FAIL gaps_final_valid: got %b/%b exp 1", v1, v0); else n_pass++;
      for (int i = 0; i < 16; i++) begin
         n_chk++; if (o1[i] !== e1[i] || o0[i] !== e0[i]) $display("FAIL gaps_lane %0d: got %h/%h exp %h/%h", i, o1[i], o0[i], e1[i], e0[i]); else n_pass++;
      end
   endtask

   task automatic test_clear;
      int pulses = 0;
      cyc(0, 0, 1);
      n_chk++; if (err1 !== 0 || err0 !== 0) $display("FAIL clear_empty_err: got %b/%b exp 0", err1, err0); else n_pass++;
      repeat (5) cyc(1, $urandom, 0);
      cyc(0, 0, 1);
      n_chk++; if (err1 !== 1 || err0 !== 1) $display("FAIL clear_partial_err: got %b/%b exp 1", err1, err0); else n_pass++;
      for (int k = 0; k < 16; k++) begin
         cyc(1, $urandom, 0);
         if (v0) pulses++;
         n_chk++; if (v1 !== m_valid || v0 !== m_valid) $display("FAIL clear_valid k=%0d: got %b/%b exp %b", k, v1, v0, m_valid); else n_pass++;
      end
      n_chk++; if (pulses != 1) $display("FAIL clear_pulses: got %0d exp 1", pulses); else n_pass++;
      for (int i = 0; i < 16; i++) begin
         n_chk++; if (o1[i] !== e1[i] || o0[i] !== e0[i]) $display("FAIL clear_lane %0d: got %h/%h exp %h/%h", i, o1[i], o0[i], e1[i], e0[i]); else n_pass++;
      end
      repeat (15) cyc(1, $urandom, 0);
      cyc(1, $urandom, 1);
      n_chk++; if (v1 !== 0 || v0 !== 0) $display("FAIL clear_16th_valid: got %b/%b exp 0", v1, v0); else n_pass++;
      cyc(0, 0, 0);
      n_chk++; if (v1 !== 0 || v0 !== 0) $display("FAIL clear_16th_late: got %b/%b exp 0", v1, v0); else n_pass++;
      n_chk++; if (o1 !== e1 || o0 !== e0) $display("FAIL clear_16th_hold: got %h exp %h", o0, e0); else n_pass++;
      n_chk++; if (err1 !== m_err || err0 !== m_err) $display("FAIL clear_sticky: got %b/%b exp %b", err1, err0, m_err); else n_pass++;
      repeat (16) cyc(1, $urandom, 0);
      n_chk++; if (v1 !== 1 || v0 !== 1 || o1 !== e1 || o0 !== e0) $display("FAIL clear_refill: got %b %h exp 1 %h", v0, o0, e0); else n_pass++;
   endtask

   task automatic test_mid_reset;
      repeat (9) cyc(1, $urandom, 0);
      rst = 1;
      #1;
      n_chk++; if (o1 !== '0 || o0 !== '0) $display("FAIL midrst_data: got %h / %h exp 0", o1, o0); else n_pass++;
      n_chk++; if (v1 !== 0 || v0 !== 0 || err1 !== 0 || err0 !== 0) $display("FAIL midrst_flags: got %b%b%b%b exp 0000", v1, v0, err1, err0); else n_pass++;
      @(posedge clk); #1;
      rst = 0;
      model_reset();
      for (int k = 0; k < 16; k++) begin
         cyc(1, $urandom, 0);
         n_chk++; if (v1 !== m_valid || v0 !== m_valid) $display("FAIL midrst_valid k=%0d: got %b/%b exp %b", k, v1, v0, m_valid); else n_pass++;
      end
      for (int i = 0; i < 16; i++) begin
         n_chk++; if (o1[i] !== e1[i] || o0[i] !== e0[i]) $display("FAIL midrst_lane %0d: got %h/%h exp %h/%h", i, o1[i], o0[i], e1[i], e0[i]); else n_pass++;
      end
   endtask

   task automatic test_random;
      for (int t = 0; t < 200; t++) begin
         cyc($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 40) == 0);
         n_chk++; if (v1 !== m_valid || v0 !== m_valid || err1 !== m_err || err0 !== m_err) $display("FAIL random_flags t=%0d: got %b%b%b%b exp %b%b", t, v1, v0, err1, err0, m_valid, m_err); else n_pass++;
         n_chk++; if (o1 !== e1 || o0 !== e0) $display("FAIL random_data t=%0d: got %h exp %h", t, o1, e1); else n_pass++;
      end
   endtask

`ifdef FFT_PACK_HOLD_EN
   task automatic test_hold;
      logic [31:0] w;
      rst = 1; #1;
      @(posedge clk); #1;
      rst = 0;
      model_reset();
      auto_done = 0;
      repeat (16) cyc(1, $urandom, 0);
      n_chk++; if (v1 !== 1 || v0 !== 1) $display("FAIL hold_frame1: got %b/%b exp 1", v1, v0); else n_pass++;
      repeat (15) cyc(1, $urandom, 0);
      n_chk++; if (rdy1 !== 0 || rdy0 !== 0) $display("FAIL hold_ready_low: got %b/%b exp 0", rdy1, rdy0); else n_pass++;
      w = $urandom;
      repeat (3) begin
         cyc(1, w, 0);
         n_chk++; if (v1 !== 0 || v0 !== 0 || rdy1 !== 0) $display("FAIL hold_stall: got v=%b rdy=%b exp v=0 rdy=0", v1, rdy1); else n_pass++;
      end
      cyc(1, w, 0, 1);
      n_chk++; if (rdy1 !== 1 || rdy0 !== 1 || v1 !== 0) $display("FAIL hold_release: got rdy=%b/%b v=%b exp rdy=1 v=0", rdy1, rdy0, v1); else n_pass++;
      cyc(1, w, 0);
      n_chk++; if (v1 !== 1 || v0 !== 1) $display("FAIL hold_frame2_valid: got %b/%b exp 1", v1, v0); else n_pass++;
      n_chk++; if (o1 !== e1 || o0 !== e0) $display("FAIL hold_frame2_data: got %h exp %h", o1, e1); else n_pass++;
      n_chk++; if (rdy1 !== m_rdy) $display("FAIL hold_model_ready: got %b exp %b", rdy1, m_rdy); else n_pass++;
      auto_done = 1;
   endtask
`endif

   initial begin
      test_reset();
      test_bitrev();
      test_back_to_back();
      test_gaps();
      test_clear();
      test_mid_reset();
      test_random();
`ifdef FFT_PACK_HOLD_EN
      test_hold();
`endif
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
